mem_arbiter: RTL and testbench

- Shares one backing-memory port between the icache refill interface and the data-memory port.
- Sits between the icache miss path and data_memory on one side, and the unified memory model or bus on the other. It replaces the tied-off icache refill (ack equal to request, NOP data).
- Sequences icache line refills as LINE_WORDS-beat bursts and data accesses as single-beat transfers, with fixed priority to data by default.

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between icache line refills and data accesses.
// Optional MEMARB_RR_EN: round-robin tie-break instead of fixed data priority.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = `XLEN,
  parameter int DATA_W     = `XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_last,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_XFER  = 2'd1,
    I_BURST = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [BW-1:0]     r_beat;
  logic [BW-1:0]     w_beat_nx;
  logic              r_m_req;
  logic              w_m_req_nx;
  logic              r_m_we;
  logic              w_m_we_nx;
  logic [3:0]        r_m_be;
  logic [3:0]        w_m_be_nx;
  logic [ADDR_W-1:0] r_m_addr;
  logic [ADDR_W-1:0] w_m_addr_nx;
  logic [DATA_W-1:0] r_m_wdata;
  logic [DATA_W-1:0] w_m_wdata_nx;

  logic w_gnt_d;
  logic w_gnt_i;
  logic w_last_beat;
  logic w_unused;

  assign w_unused = ^{i_addr[OFF-1:0], d_addr[1:0]};

`ifdef MEMARB_RR_EN
  // r_last_grant: 1 = data granted last, 0 = icache granted last
  logic r_last_grant;
  logic w_last_grant_nx;

  always_comb begin
    w_gnt_d = d_req && (!i_req || !r_last_grant);
  end

  always_comb begin
    w_last_grant_nx = r_last_grant;
    if (r_state == IDLE && (d_req || i_req))
      w_last_grant_nx = w_gnt_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_last_grant <= 1'b0;
    else
      r_last_grant <= w_last_grant_nx;
  end
`else
  always_comb begin
    w_gnt_d = d_req;
  end
`endif

  assign w_gnt_i     = i_req && !w_gnt_d;
  assign w_last_beat = (r_beat == BW'(LINE_WORDS - 1));

  always_comb begin
    w_state_nx   = r_state;
    w_beat_nx    = r_beat;
    w_m_req_nx   = r_m_req;
    w_m_we_nx    = r_m_we;
    w_m_be_nx    = r_m_be;
    w_m_addr_nx  = r_m_addr;
    w_m_wdata_nx = r_m_wdata;
    case (r_state)
      IDLE: begin
        if (w_gnt_d) begin
          w_state_nx   = D_XFER;
          w_m_req_nx   = 1'b1;
          w_m_we_nx    = d_we;
          w_m_be_nx    = d_we ? d_be : 4'b0000;
          w_m_addr_nx  = {d_addr[ADDR_W-1:2], 2'b00};
          w_m_wdata_nx = d_wdata;
        end else if (w_gnt_i) begin
          w_state_nx  = I_BURST;
          w_beat_nx   = '0;
          w_m_req_nx  = 1'b1;
          w_m_we_nx   = 1'b0;
          w_m_be_nx   = 4'b0000;
          w_m_addr_nx = {i_addr[ADDR_W-1:OFF], OFF'(0)};
        end
      end
      D_XFER: begin
        if (m_ack) begin
          w_state_nx = IDLE;
          w_m_req_nx = 1'b0;
          w_m_we_nx  = 1'b0;
          w_m_be_nx  = 4'b0000;
        end
      end
      I_BURST: begin
        if (m_ack) begin
          if (w_last_beat) begin
            w_state_nx = IDLE;
            w_m_req_nx = 1'b0;
            w_beat_nx  = '0;
          end else begin
            // m_req stays high: next beat issues without a bubble
            w_beat_nx   = r_beat + BW'(1);
            w_m_addr_nx = r_m_addr + ADDR_W'(4);
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_m_req_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_be    <= 4'b0000;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_beat    <= w_beat_nx;
      r_m_req   <= w_m_req_nx;
      r_m_we    <= w_m_we_nx;
      r_m_be    <= w_m_be_nx;
      r_m_addr  <= w_m_addr_nx;
      r_m_wdata <= w_m_wdata_nx;
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_be    = r_m_be;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

  assign d_ack   = (r_state == D_XFER) && m_ack;
  assign i_ack   = (r_state == I_BURST) && m_ack;
  assign i_last  = i_ack && w_last_beat;
  assign d_rdata = m_rdata;
  assign i_rdata = m_rdata;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle vectors for mem_arbiter: data, refill, collisions,
// wait states, async reset mid-burst and spurious acks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic        i_last;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .i_last(i_last), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );

  typedef struct {
    logic        dreq;
    logic        dwe;
    logic        ireq;
    logic        mack;
    logic [31:0] mrd;
    logic        emreq;
    logic        emwe;
    logic [3:0]  embe;
    logic [31:0] emaddr;
    logic        edack;
    logic        eiack;
    logic        eilast;
    logic        ebusy;
  } vec_t;

  function automatic vec_t mk(
    input logic dr, input logic dw, input logic ir, input logic ma,
    input logic [31:0] rd, input logic er, input logic ew,
    input logic [3:0] eb, input logic [31:0] ea, input logic ed,
    input logic ei, input logic el, input logic ebz);
    vec_t v;
    v.dreq = dr; v.dwe = dw; v.ireq = ir; v.mack = ma; v.mrd = rd;
    v.emreq = er; v.emwe = ew; v.embe = eb; v.emaddr = ea;
    v.edack = ed; v.eiack = ei; v.eilast = el; v.ebusy = ebz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    d_req   = v.dreq;
    d_we    = v.dwe;
    i_req   = v.ireq;
    m_ack   = v.mack;
    m_rdata = v.mrd;
    #1;
    chk({nm, ".m_req"}, 32'(m_req), 32'(v.emreq));
    chk({nm, ".m_we"}, 32'(m_we), 32'(v.emwe));
    chk({nm, ".m_be"}, 32'(m_be), 32'(v.embe));
    chk({nm, ".m_addr"}, m_addr, v.emaddr);
    chk({nm, ".d_ack"}, 32'(d_ack), 32'(v.edack));
    chk({nm, ".i_ack"}, 32'(i_ack), 32'(v.eiack));
    chk({nm, ".i_last"}, 32'(i_last), 32'(v.eilast));
    chk({nm, ".busy"}, 32'(busy), 32'(v.ebusy));
    if (v.emreq && v.emwe)
      chk({nm, ".m_wdata"}, m_wdata, 32'hDEAD_BEEF);
    if (v.edack)
      chk({nm, ".d_rdata"}, d_rdata, v.mrd);
    if (v.eiack)
      chk({nm, ".i_rdata"}, i_rdata, v.mrd);
  endtask

  vec_t tbl[19];
  logic [31:0] la;

  initial begin
    reset   = 1'b0;
    i_req   = 1'b0;
    i_addr  = 32'h0000_100C;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'b0011;
    d_addr  = 32'h0000_2006;
    d_wdata = 32'hDEAD_BEEF;
    m_ack   = 1'b0;
    m_rdata = '0;

    // dreq dwe ireq mack rdata | mreq mwe mbe maddr dack iack ilast busy
    tbl[0]  = mk(0,0,0,0,32'h0,  0,0,4'h0,32'h0,   0,0,0,0);
    tbl[1]  = mk(1,1,0,0,32'h0,  0,0,4'h0,32'h0,   0,0,0,0);
    tbl[2]  = mk(1,1,0,0,32'h0,  1,1,4'h3,32'h2004,0,0,0,1);
    tbl[3]  = mk(1,1,0,1,32'h11, 1,1,4'h3,32'h2004,1,0,0,1);
    tbl[4]  = mk(0,0,1,0,32'h0,  0,0,4'h0,32'h2004,0,0,0,0);
    tbl[5]  = mk(0,0,1,1,32'hA0, 1,0,4'h0,32'h1000,0,1,0,1);
    tbl[6]  = mk(0,0,1,1,32'hA1, 1,0,4'h0,32'h1004,0,1,0,1);
    tbl[7]  = mk(0,0,1,1,32'hA2, 1,0,4'h0,32'h1008,0,1,0,1);
    tbl[8]  = mk(0,0,1,1,32'hA3, 1,0,4'h0,32'h100C,0,1,1,1);
    tbl[9]  = mk(0,0,0,1,32'h77, 0,0,4'h0,32'h100C,0,0,0,0);
    tbl[10] = mk(0,0,0,1,32'h78, 0,0,4'h0,32'h100C,0,0,0,0);
    tbl[11] = mk(1,0,1,0,32'h0,  0,0,4'h0,32'h100C,0,0,0,0);
    tbl[12] = mk(1,0,1,1,32'h55, 1,0,4'h0,32'h2004,1,0,0,1);
    tbl[13] = mk(0,0,1,0,32'h0,  0,0,4'h0,32'h2004,0,0,0,0);
    tbl[14] = mk(0,0,1,1,32'hB0, 1,0,4'h0,32'h1000,0,1,0,1);
    tbl[15] = mk(0,0,1,1,32'hB1, 1,0,4'h0,32'h1004,0,1,0,1);
    tbl[16] = mk(0,0,1,1,32'hB2, 1,0,4'h0,32'h1008,0,1,0,1);
    tbl[17] = mk(0,0,1,1,32'hB3, 1,0,4'h0,32'h100C,0,1,1,1);
    tbl[18] = mk(0,0,0,0,32'h0,  0,0,4'h0,32'h100C,0,0,0,0);

    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 19; i++)
      run_vec(tbl[i], $sformatf("tbl%0d", i));

    // repeated collision right after a lone data grant
    run_vec(mk(1,0,0,0,32'h0, 0,0,4'h0,32'h100C,0,0,0,0), "col_a1");
    run_vec(mk(1,0,0,1,32'h66,1,0,4'h0,32'h2004,1,0,0,1), "col_a2");
    run_vec(mk(1,0,1,0,32'h0, 0,0,4'h0,32'h2004,0,0,0,0), "col_a3");
`ifdef MEMARB_RR_EN
    for (int k = 0; k < 4; k++)
      run_vec(mk(1,0,1,1,32'hC0 + 32'(k),1,0,4'h0,32'h1000 + 32'(4*k),
                 0,1,(k == 3),1), $sformatf("rr_beat%0d", k));
    run_vec(mk(1,0,0,0,32'h0, 0,0,4'h0,32'h100C,0,0,0,0), "rr_idle");
    run_vec(mk(1,0,0,1,32'h77,1,0,4'h0,32'h2004,1,0,0,1), "rr_data");
    la = 32'h2004;
`else
    run_vec(mk(1,0,1,1,32'h66,1,0,4'h0,32'h2004,1,0,0,1), "fp_data");
    run_vec(mk(0,0,1,0,32'h0, 0,0,4'h0,32'h2004,0,0,0,0), "fp_idle");
    for (int k = 0; k < 4; k++)
      run_vec(mk(0,0,1,1,32'hC0 + 32'(k),1,0,4'h0,32'h1000 + 32'(4*k),
                 0,1,(k == 3),1), $sformatf("fp_beat%0d", k));
    la = 32'h100C;
`endif

    // d_req raised during beat 2 of a burst with 3 wait states per beat
    run_vec(mk(0,0,1,0,32'h0,0,0,4'h0,la,0,0,0,0), "ws_start");
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++)
        run_vec(mk((k >= 1),1,1,0,32'h0,1,0,4'h0,32'h1000 + 32'(4*k),
                   0,0,0,1), $sformatf("ws_wait%0d_%0d", k, w));
      run_vec(mk((k >= 1),1,1,1,32'hD0 + 32'(k),1,0,4'h0,
                 32'h1000 + 32'(4*k),0,1,(k == 3),1),
              $sformatf("ws_beat%0d", k));
    end
    run_vec(mk(1,1,0,0,32'h0, 0,0,4'h0,32'h100C,0,0,0,0), "ws_idle");
    run_vec(mk(1,1,0,0,32'h0, 1,1,4'h3,32'h2004,0,0,0,1), "ws_dwait");
    run_vec(mk(1,1,0,1,32'h99,1,1,4'h3,32'h2004,1,0,0,1), "ws_dack");
    run_vec(mk(0,0,0,0,32'h0, 0,0,4'h0,32'h2004,0,0,0,0), "ws_end");

    // asynchronous reset during beat 2, i_req held across it
    run_vec(mk(0,0,1,0,32'h0, 0,0,4'h0,32'h2004,0,0,0,0), "rst_start");
    run_vec(mk(0,0,1,1,32'hE0,1,0,4'h0,32'h1000,0,1,0,1), "rst_beat0");
    run_vec(mk(0,0,1,1,32'hE1,1,0,4'h0,32'h1004,0,1,0,1), "rst_beat1");
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async.m_req", 32'(m_req), 32'd0);
    chk("rst_async.i_ack", 32'(i_ack), 32'd0);
    chk("rst_async.busy", 32'(busy), 32'd0);
    chk("rst_async.m_addr", m_addr, 32'h0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++)
      run_vec(mk(0,0,1,1,32'hF0 + 32'(k),1,0,4'h0,32'h1000 + 32'(4*k),
                 0,1,(k == 3),1), $sformatf("rst_re%0d", k));
    run_vec(mk(0,0,0,0,32'h0, 0,0,4'h0,32'h100C,0,0,0,0), "rst_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
